// File: rtl/hello_tdest_demux.sv
// rtl/hello_tdest_demux.sv - packet-level TDEST demultiplexer behind the SRIO HELLO FTYPE router
module hello_tdest_demux #(
   parameter int DATA_W = 64,
   parameter int USER_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              AXIS_ACLK,
   input  logic              AXIS_ARESET,

   input  logic              S_AXIS_TVALID,
   output logic              S_AXIS_TREADY,
   input  logic [DATA_W-1:0] S_AXIS_TDATA,
   input  logic              S_AXIS_TLAST,
   input  logic [1:0]        S_AXIS_TDEST,
   input  logic [USER_W-1:0] S_AXIS_TUSER,

   output logic              M0_AXIS_TVALID,
   input  logic              M0_AXIS_TREADY,
   output logic [DATA_W-1:0] M0_AXIS_TDATA,
   output logic              M0_AXIS_TLAST,
   output logic [USER_W-1:0] M0_AXIS_TUSER,

   output logic              M1_AXIS_TVALID,
   input  logic              M1_AXIS_TREADY,
   output logic [DATA_W-1:0] M1_AXIS_TDATA,
   output logic              M1_AXIS_TLAST,
   output logic [USER_W-1:0] M1_AXIS_TUSER,

   output logic              M2_AXIS_TVALID,
   input  logic              M2_AXIS_TREADY,
   output logic [DATA_W-1:0] M2_AXIS_TDATA,
   output logic              M2_AXIS_TLAST,
   output logic [USER_W-1:0] M2_AXIS_TUSER,

   output logic [CNT_W-1:0]  drop_count,
   output logic [CNT_W-1:0]  pkt_count_0,
   output logic [CNT_W-1:0]  pkt_count_1,
   output logic [CNT_W-1:0]  pkt_count_2
);

   typedef enum logic [1:0] {
      ST_SOP  = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [1:0] DEST_DROP = 2'd3;

   state_t              state_q;
   logic [1:0]          dest_q;

   logic                hold_vld_q, hold_vld_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic                hold_last_q, hold_last_d;
   logic [USER_W-1:0]   hold_user_q, hold_user_d;
   logic [1:0]          hold_dest_q, hold_dest_d;

   logic [CNT_W-1:0]    pkt_cnt_q [3];
   logic [CNT_W-1:0]    pkt_cnt_d [3];
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

   logic                sel_ready;
   logic                d_xfr;
   logic                s_ready;
   logic                s_xfr;
   logic                sop_drop;
   logic                load;
   logic [1:0]          load_dest;
   logic                drop_eop;

   // Ready of whichever master the held beat is addressed to
   always_comb begin
      sel_ready = 1'b0;
      case (hold_dest_q)
         2'd0:    sel_ready = M0_AXIS_TREADY;
         2'd1:    sel_ready = M1_AXIS_TREADY;
         default: sel_ready = M2_AXIS_TREADY;
      endcase
   end

   assign d_xfr = hold_vld_q & sel_ready;

   // Ready passes straight through from the selected master so a draining register can refill
   // in the same clock; it is forced low while reset is asserted so no beat is taken then.
   assign s_ready = ~AXIS_ARESET & ((state_q == ST_DROP) | ~hold_vld_q | d_xfr);
   assign s_xfr   = S_AXIS_TVALID & s_ready;

   // A first beat tagged for dest 3 is discarded rather than loaded
   assign sop_drop  = (state_q == ST_SOP) & (S_AXIS_TDEST == DEST_DROP);
   assign load      = s_xfr & ((state_q == ST_FWD) | ((state_q == ST_SOP) & ~sop_drop));
   assign load_dest = (state_q == ST_SOP) ? S_AXIS_TDEST : dest_q;
   assign drop_eop  = s_xfr & S_AXIS_TLAST & (sop_drop | (state_q == ST_DROP));

   // Packet framing state machine; destination is locked on the first beat of each packet
   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         state_q <= ST_SOP;
         dest_q  <= 2'd0;
      end else if (s_xfr) begin
         case (state_q)
            ST_SOP: begin
               dest_q <= S_AXIS_TDEST;
               if (!S_AXIS_TLAST) begin
                  state_q <= sop_drop ? ST_DROP : ST_FWD;
               end
            end
            ST_FWD: begin
               if (S_AXIS_TLAST) begin
                  state_q <= ST_SOP;
               end
            end
            ST_DROP: begin
               if (S_AXIS_TLAST) begin
                  state_q <= ST_SOP;
               end
            end
            default: state_q <= ST_SOP;
         endcase
      end
   end

   // Holding register next state: reload on accept (even while draining), else clear on drain
   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      hold_last_d = hold_last_q;
      hold_user_d = hold_user_q;
      hold_dest_d = hold_dest_q;
      if (load) begin
         hold_vld_d  = 1'b1;
         hold_data_d = S_AXIS_TDATA;
         hold_last_d = S_AXIS_TLAST;
         hold_user_d = S_AXIS_TUSER;
         hold_dest_d = load_dest;
      end else if (d_xfr) begin
         hold_vld_d  = 1'b0;
      end
   end

   // One-deep output register shared by all three masters
   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
         hold_last_q <= 1'b0;
         hold_user_q <= '0;
         hold_dest_q <= 2'd0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         hold_last_q <= hold_last_d;
         hold_user_q <= hold_user_d;
         hold_dest_q <= hold_dest_d;
      end
   end

   // Counter next state: per-port counters wrap, the drop counter sticks at all-ones
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         pkt_cnt_d[n] = pkt_cnt_q[n];
         if (d_xfr && hold_last_q && (hold_dest_q == 2'(n))) begin
            pkt_cnt_d[n] = pkt_cnt_q[n] + CNT_W'(1);
         end
      end
      drop_cnt_d = drop_cnt_q;
      if (drop_eop && !(&drop_cnt_q)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   // Packet statistics registers
   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         for (int n = 0; n < 3; n++) begin
            pkt_cnt_q[n] <= '0;
         end
         drop_cnt_q <= '0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            pkt_cnt_q[n] <= pkt_cnt_d[n];
         end
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign S_AXIS_TREADY  = s_ready;

   assign M0_AXIS_TVALID = hold_vld_q & (hold_dest_q == 2'd0);
   assign M1_AXIS_TVALID = hold_vld_q & (hold_dest_q == 2'd1);
   assign M2_AXIS_TVALID = hold_vld_q & (hold_dest_q == 2'd2);

   assign M0_AXIS_TDATA  = hold_data_q;
   assign M1_AXIS_TDATA  = hold_data_q;
   assign M2_AXIS_TDATA  = hold_data_q;
   assign M0_AXIS_TLAST  = hold_last_q;
   assign M1_AXIS_TLAST  = hold_last_q;
   assign M2_AXIS_TLAST  = hold_last_q;
   assign M0_AXIS_TUSER  = hold_user_q;
   assign M1_AXIS_TUSER  = hold_user_q;
   assign M2_AXIS_TUSER  = hold_user_q;

   assign drop_count     = drop_cnt_q;
   assign pkt_count_0    = pkt_cnt_q[0];
   assign pkt_count_1    = pkt_cnt_q[1];
   assign pkt_count_2    = pkt_cnt_q[2];

endmodule
